// File: rtl/input_debouncer_pkg.sv
// Shared types and defaults for the input debouncer and its synchronizer.
//   deb_state_t          : debouncer FSM state (STABLE, SETTLING)
//   STABLE_COUNT_DEFAULT : default settle time in clk cycles (10 ms at 10 MHz)
//   RESET_LEVEL_DEFAULT  : default level of the debounced output and sync flops
//   STABLE_COUNT_MIN     : smallest legal settle time
//   cnt_width()          : settle counter width for a given settle time
package input_debouncer_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } deb_state_t;

    localparam int unsigned STABLE_COUNT_DEFAULT = 100000;
    localparam logic        RESET_LEVEL_DEFAULT  = 1'b0;
    localparam int unsigned STABLE_COUNT_MIN     = 2;

    // Counter only has to reach STABLE_COUNT-1; clamp keeps illegal values elaboratable
    // long enough for the range check in the top to report them.
    function automatic int unsigned cnt_width(input int unsigned stable_count);
        int unsigned w;
        w = 1;
        if (stable_count >= STABLE_COUNT_MIN) begin
            w = 32'($clog2(stable_count));
        end
        return w;
    endfunction

endpackage

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin.
// Parameters:
//   RESET_LEVEL : value loaded into both flops while rst is high
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   d   : asynchronous input level
//   q   : synchronized level (second flop)
module sync_2ff
    import input_debouncer_pkg::*;
#(
    parameter logic RESET_LEVEL = RESET_LEVEL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_LEVEL;
            q    <= RESET_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for a bouncing mechanical input (button or switch).
// A change on raw_in is accepted only after the synchronized level has differed
// from the debounced level for STABLE_COUNT consecutive cycles; any return to
// the old level during that window restarts the wait.
// Parameters:
//   STABLE_COUNT : consecutive stable cycles required to accept a change (>= 2)
//   RESET_LEVEL  : level_out and synchronizer value during and after reset
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   raw_in     : asynchronous bouncing pin level
//   level_out  : debounced level
//   rise_pulse : one-cycle strobe in the first cycle level_out is 1 after a change
//   fall_pulse : one-cycle strobe in the first cycle level_out is 0 after a change
// Build option:
//   INPUT_DEBOUNCER_EDGE_EN : when defined, rise_pulse/fall_pulse are generated;
//                             otherwise both are tied to 0.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = STABLE_COUNT_DEFAULT,
    parameter logic        RESET_LEVEL  = RESET_LEVEL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned      CNT_W    = cnt_width(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    // Settle times below two cycles cannot be expressed by the counter scheme.
    if (STABLE_COUNT < STABLE_COUNT_MIN) begin : g_bad_stable_count
        $error("input_debouncer: STABLE_COUNT must be >= 2");
    end

    logic             synced;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             differ_c;
    logic             accept_c;

    sync_2ff #(
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (synced)
    );

    assign differ_c = (synced != level_out);
    // Last settling cycle with the new level still present: flip on this edge.
    assign accept_c = (state == SETTLING) && differ_c && (cnt == CNT_LAST);

    // Debounce FSM; counter counts cycles the new level has been seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= STABLE;
            cnt       <= '0;
            level_out <= RESET_LEVEL;
        end else begin
            case (state)
                STABLE: begin
                    if (differ_c) begin
                        state <= SETTLING;
                        cnt   <= CNT_W'(1);
                    end
                end
                SETTLING: begin
                    if (!differ_c) begin
                        // Bounce back to the accepted level: drop the attempt.
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (accept_c) begin
                        state     <= STABLE;
                        cnt       <= '0;
                        level_out <= ~level_out;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef INPUT_DEBOUNCER_EDGE_EN
    // Strobes are registered on the same edge that flips level_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= accept_c && !level_out;
            fall_pulse <= accept_c && level_out;
        end
    end
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with STABLE_COUNT=4, RESET_LEVEL=0.
// The stimulus process pushes each expected level change (cycle, level, strobes)
// into a queue; a negedge monitor pops and compares whenever the DUT shows an
// output event (level_out change or any strobe high).
module tb_input_debouncer;

    localparam int unsigned SC  = 4;
    // Drive after edge N -> captured at N+1 -> level flips at edge N+1+SC+1.
    localparam int          LAT = SC + 2;
`ifdef INPUT_DEBOUNCER_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    typedef struct {
        int   cyc;
        logic level;
        logic rise;
        logic fall;
    } evt_t;

    logic clk;
    logic rst;
    logic raw_in;
    logic level_out;
    logic rise_pulse;
    logic fall_pulse;

    int   cyc;
    int   n_cmp;
    int   n_fail;
    logic prev_level;
    evt_t exp_q[$];

    input_debouncer #(
        .STABLE_COUNT (SC),
        .RESET_LEVEL  (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_evt(input int at_cyc, input logic lvl);
        evt_t e;
        e.cyc   = at_cyc;
        e.level = lvl;
        e.rise  = EDGE_EN & lvl;
        e.fall  = EDGE_EN & ~lvl;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_quiet(input string tag, input logic lvl);
        chk({tag, "_level"}, 32'(level_out), 32'(lvl));
        chk({tag, "_rise"}, 32'(rise_pulse), 32'd0);
        chk({tag, "_fall"}, 32'(fall_pulse), 32'd0);
    endtask

    // Monitor: every output event must match the head of the expectation queue.
    initial prev_level = 1'b0;
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (level_out !== prev_level || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event: cycle %0d level=%b rise=%b fall=%b, required no event",
                             cyc, level_out, rise_pulse, fall_pulse);
                end else begin
                    evt_t e;
                    e = exp_q.pop_front();
                    chk("evt_cycle", 32'(cyc), 32'(e.cyc));
                    chk("evt_level", 32'(level_out), 32'(e.level));
                    chk("evt_rise", 32'(rise_pulse), 32'(e.rise));
                    chk("evt_fall", 32'(fall_pulse), 32'(e.fall));
                end
            end
            prev_level = level_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        raw_in = 1'b1;

        // Reset held 3 cycles with raw_in high: output stays at reset level.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_quiet("reset", 1'b0);
        end
        rst = 1'b0;
        push_evt(cyc + LAT, 1'b1);
        step();
        chk_quiet("post_reset", 1'b0);
        idle(10);

        // Clean fall, then clean rise (single-transition latency).
        raw_in = 1'b0;
        push_evt(cyc + LAT, 1'b0);
        idle(10);
        raw_in = 1'b1;
        push_evt(cyc + LAT, 1'b1);
        idle(10);

        // Level 1: low for 3 cycles is rejected, low for 4+ is accepted.
        raw_in = 1'b0;
        idle(3);
        raw_in = 1'b1;
        idle(10);
        chk_quiet("short_low", 1'b1);
        raw_in = 1'b0;
        push_evt(cyc + LAT, 1'b0);
        idle(10);

        // Bounce: toggle every 2 cycles for 20 cycles, then settle high.
        for (int i = 0; i < 10; i++) begin
            raw_in = (i % 2 == 0) ? 1'b1 : 1'b0;
            idle(2);
            chk_quiet("bounce", 1'b0);
        end
        raw_in = 1'b1;
        push_evt(cyc + LAT, 1'b1);
        idle(10);
        raw_in = 1'b0;
        push_evt(cyc + LAT, 1'b0);
        idle(10);

        // Reset after 3 settling cycles abandons the change with no strobe.
        raw_in = 1'b1;
        idle(5);
        rst = 1'b1;
        step();
        chk_quiet("mid_reset", 1'b0);
        step();
        chk_quiet("mid_reset", 1'b0);
        rst = 1'b0;
        push_evt(cyc + LAT, 1'b1);
        step();
        chk_quiet("mid_post_reset", 1'b0);
        idle(12);
        chk("final_level", 32'(level_out), 32'd1);

        chk("pending_events", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter STABLE_COUNT, default 100000, meaning consecutive clk cycles of stable synchronized input required to accept a change (10 ms at 10 MHz).
REQ-002 SHALL have parameter RESET_LEVEL, default 1'b0, meaning the value of level_out and of the synchronizer flops during and after reset.
REQ-003 SHALL have port clk, input, 1, meaning single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, synchronous, active-high.
REQ-005 SHALL have port raw_in, input, 1, meaning asynchronous, bouncing pin level (button or switch).
REQ-006 SHALL have port level_out, output, 1, meaning debounced level.
REQ-007 SHALL have port rise_pulse, output, 1, meaning one-cycle strobe on accepted 0->1 change.
REQ-008 SHALL have port fall_pulse, output, 1, meaning one-cycle strobe on accepted 1->0 change.

Function
REQ-009 SHALL pass raw_in through a two-flop synchronizer; the second-flop output is "synced".
REQ-010 SHALL implement a two-state FSM: STABLE (synced == level_out, counter held at 0) and SETTLING (synced != level_out, counter incrementing).
REQ-011 SHALL move STABLE->SETTLING on the first edge at which synced != level_out, loading the counter with 1.
REQ-012 SHALL, in SETTLING, return to STABLE with counter 0 and level_out unchanged on any edge at which synced == level_out (bounce rejected).
REQ-013 SHALL, in SETTLING, on the edge at which synced still differs and counter == STABLE_COUNT-1, invert level_out, clear counter and return to STABLE.
REQ-014 SHALL give total latency from the edge first capturing a new raw_in value to the level_out change of exactly STABLE_COUNT+1 cycles, provided raw_in stays stable.
REQ-015 SHALL assert rise_pulse (fall_pulse) for exactly the one cycle in which level_out is first 1 (0) after a change; never both in the same cycle.
REQ-016 SHALL size the counter as $clog2(STABLE_COUNT) bits; the counter SHALL never exceed STABLE_COUNT-1 and never wrap.
REQ-017 SHALL support STABLE_COUNT >= 2; smaller values are illegal and SHALL trigger an elaboration-time error.

Reset
REQ-018 SHALL, while rst is high at a clk edge, set both synchronizer flops and level_out to RESET_LEVEL, counter to 0, FSM to STABLE, rise_pulse and fall_pulse to 0.
REQ-019 SHALL abandon any in-progress SETTLING on reset with no pulse emitted; after rst deasserts, raw_in is re-evaluated from scratch.

Configuration
REQ-020 SHALL use macro INPUT_DEBOUNCER_EDGE_EN: defined -> rise_pulse/fall_pulse behave per REQ-015; undefined -> edge logic not compiled, both outputs tied constant 0, level_out behaviour unchanged.

Structure
REQ-021 SHALL place the FSM state enum (STABLE, SETTLING) and default constants (STABLE_COUNT default, RESET_LEVEL default) in shared package input_debouncer_pkg.
REQ-022 SHALL instantiate the synchronizer as sub-module sync_2ff (parameter RESET_LEVEL), reusable for other pin inputs.

Verification (STABLE_COUNT=4, RESET_LEVEL=0)
REQ-023 SHALL cover: rst high 3 cycles with raw_in=1 -> level_out=0, both pulses 0 throughout and first cycle after release.
REQ-024 SHALL cover: raw_in 0->1 held steady -> level_out=1 exactly 5 cycles after the capturing edge; rise_pulse high that one cycle only.
REQ-025 SHALL cover: raw_in toggling every 2 cycles for 20 cycles, then steady 1 -> level_out stays 0 during bounce, rises 5 cycles after the final edge, exactly one rise_pulse, zero fall_pulse.
REQ-026 SHALL cover: level_out=1, raw_in low for 3 cycles then high -> no change, no pulses; raw_in low for 4+ cycles -> fall after 5 cycles, one fall_pulse.
REQ-027 SHALL cover: rst asserted after 3 SETTLING cycles -> counter 0, level_out 0, no pulse; with raw_in still 1 after release, rise occurs 5 cycles after the first post-reset capturing edge.
REQ-028 SHALL cover: build without INPUT_DEBOUNCER_EDGE_EN, rerun REQ-024 stimulus -> level_out identical, rise_pulse and fall_pulse constant 0.
